// File: rtl/elevator_call_scheduler.sv
// Debounces the call buttons, latches pending calls and issues one one-hot floor request at a time.
// Optional build macro CALL_CANCEL_EN: a re-press cancels a pending call that is not the current target.
module elevator_call_scheduler #(
    parameter int DEB_CYCLES   = 50000,
    parameter int DEB_W        = 16,
    parameter int MOVE_TIMEOUT = 1000,
    parameter int DWELL_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    input  logic       mup,
    input  logic       mdw,
    output logic       p1,
    output logic       p2,
    output logic       p3,
    output logic [2:0] pend,
    output logic [1:0] cur_floor,
    output logic       busy
);

    localparam int TMO_W = $clog2(MOVE_TIMEOUT + 1);
    localparam int DW_W  = $clog2(DWELL_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(MOVE_TIMEOUT - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ARRIVE, DWELL} state_t;

    function automatic logic [2:0] floor_mask(input logic [1:0] fl);
        floor_mask = 3'b000;
        case (fl)
            2'd1:    floor_mask = 3'b001;
            2'd2:    floor_mask = 3'b010;
            2'd3:    floor_mask = 3'b100;
            default: floor_mask = 3'b000;
        endcase
    endfunction

    logic [2:0] b_raw;
    logic [2:0] floors;
    logic [2:0] press;
    logic       moving;

    assign b_raw  = {b3, b2, b1};
    assign floors = {f3, f2, f1};
    assign moving = mup | mdw;

    // Press fires on the same edge the accepted level rises, so pend follows 2 + DEB_CYCLES after a clean edge.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            logic             sync0_reg;
            logic             sync1_reg;
            logic             acc_reg;
            logic [DEB_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync0_reg <= 1'b0;
                    sync1_reg <= 1'b0;
                    acc_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync0_reg <= b_raw[gi];
                    sync1_reg <= sync0_reg;
                    if (sync1_reg == acc_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        acc_reg <= sync1_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = sync1_reg && !acc_reg && (cnt_reg == DEB_LAST);
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [2:0]       pend_reg, pend_next;
    logic [2:0]       p_reg, p_next;
    logic [1:0]       cur_reg, cur_next;
    logic [1:0]       target_reg, target_next;
    logic             dir_up_reg, dir_up_next;
    logic             trip_up_reg, trip_up_next;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic [DW_W-1:0]  dwell_reg, dwell_next;

    logic [1:0] pick;
    logic [2:0] cur_mask, tgt_mask;
    logic [2:0] clr, accept, set, tog;

    assign cur_mask = floor_mask(cur_reg);
    assign tgt_mask = floor_mask(target_reg);

    // Nearest pending floor; only floor 2 can see a tie, resolved by the last travel direction.
    always_comb begin
        pick = 2'd1;
        case (cur_reg)
            2'd1:    pick = pend_reg[1] ? 2'd2 : 2'd3;
            2'd3:    pick = pend_reg[1] ? 2'd2 : 2'd1;
            default: begin
                if (pend_reg[0] && pend_reg[2]) pick = dir_up_reg ? 2'd3 : 2'd1;
                else if (pend_reg[2])           pick = 2'd3;
                else                            pick = 2'd1;
            end
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        p_next       = p_reg;
        target_next  = target_reg;
        dir_up_next  = dir_up_reg;
        trip_up_next = trip_up_reg;
        tmo_next     = tmo_reg;
        dwell_next   = dwell_reg;
        cur_next     = cur_reg;
        clr          = 3'b000;

        case (floors)
            3'b001:  cur_next = 2'd1;
            3'b010:  cur_next = 2'd2;
            3'b100:  cur_next = 2'd3;
            default: cur_next = cur_reg;
        endcase

        case (state_reg)
            IDLE: begin
                if (pend_reg != 3'b000 && !moving) begin
                    if ((pend_reg & cur_mask) != 3'b000) begin
                        clr = cur_mask;
                    end else begin
                        target_next  = pick;
                        trip_up_next = (pick > cur_reg);
                        p_next       = floor_mask(pick);
                        tmo_next     = '0;
                        state_next   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (moving) begin
                    p_next     = 3'b000;
                    state_next = WAIT_ARRIVE;
                end else if (tmo_reg == TMO_LAST) begin
                    p_next     = 3'b000;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            WAIT_ARRIVE: begin
                if ((floors & tgt_mask) != 3'b000 && !moving) begin
                    clr         = tgt_mask;
                    dir_up_next = trip_up_reg;
                    dwell_next  = '0;
                    state_next  = DWELL;
                end
            end
            DWELL: begin
                if (dwell_reg == DWELL_LAST) state_next = IDLE;
                else                         dwell_next = dwell_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase

        // Presses at the floor the idle car is standing at are dropped; clears win over same-cycle presses.
        accept = press & ((state_reg == IDLE) ? ~floors : 3'b111);
        set    = accept & ~pend_reg;
`ifdef CALL_CANCEL_EN
        tog    = accept & pend_reg &
                 (((state_reg == ISSUE) || (state_reg == WAIT_ARRIVE)) ? ~tgt_mask : 3'b111);
`else
        tog    = 3'b000;
`endif
        pend_next = (pend_reg | set) & ~tog & ~clr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pend_reg    <= 3'b000;
            p_reg       <= 3'b000;
            cur_reg     <= 2'd1;
            target_reg  <= 2'd1;
            dir_up_reg  <= 1'b1;
            trip_up_reg <= 1'b1;
            tmo_reg     <= '0;
            dwell_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            pend_reg    <= pend_next;
            p_reg       <= p_next;
            cur_reg     <= cur_next;
            target_reg  <= target_next;
            dir_up_reg  <= dir_up_next;
            trip_up_reg <= trip_up_next;
            tmo_reg     <= tmo_next;
            dwell_reg   <= dwell_next;
        end
    end

    assign p1        = p_reg[0];
    assign p2        = p_reg[1];
    assign p3        = p_reg[2];
    assign pend      = pend_reg;
    assign cur_floor = cur_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed and randomized bench for elevator_call_scheduler against a behavioural call/floor model.
module tb_elevator_call_scheduler;

    localparam int DEB = 4;
    localparam int MTO = 8;
    localparam int DWL = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
    logic       f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
    logic       mup = 1'b0, mdw = 1'b0;
    logic       p1, p2, p3;
    logic [2:0] pend;
    logic [1:0] cur_floor;
    logic       busy;

    int checks = 0;
    int failures = 0;

    elevator_call_scheduler #(
        .DEB_CYCLES(DEB), .DEB_W(16), .MOVE_TIMEOUT(MTO), .DWELL_CYCLES(DWL)
    ) dut (
        .clk(clk), .reset(reset),
        .b1(b1), .b2(b2), .b3(b3),
        .f1(f1), .f2(f2), .f3(f3),
        .mup(mup), .mdw(mdw),
        .p1(p1), .p2(p2), .p3(p3),
        .pend(pend), .cur_floor(cur_floor), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: phases of a trip, floor numbers as integers, button history as sample windows.
    localparam int PH_IDLE = 0, PH_REQUEST = 1, PH_TRAVEL = 2, PH_DOORS = 3;
    int           m_phase, m_cur, m_target, m_count;
    bit           m_up, m_trip_up;
    bit [2:0]     m_pend, m_p, m_level;
    bit [DEB+1:0] m_hist [3];

    task automatic model_reset();
        m_phase = PH_IDLE; m_cur = 1; m_target = 1; m_count = 0;
        m_up = 1'b1; m_trip_up = 1'b1;
        m_pend = '0; m_p = '0; m_level = '0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
    endtask

    task automatic model_step();
        bit [2:0] bv, fv, press, accept, clr, tog;
        bit       moving;
        int       best, bestd, d, nf;
        bv = {b3, b2, b1};
        fv = {f3, f2, f1};
        moving = mup | mdw;
        press = '0; clr = '0; tog = '0;
        // Accepted level flips after DEB consecutive differing samples, seen through two sync stages.
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = {m_hist[i][DEB:0], bv[i]};
            if (m_level[i] ? (m_hist[i][DEB+1:2] == '0) : (&m_hist[i][DEB+1:2])) begin
                m_level[i] = ~m_level[i];
                press[i] = m_level[i];
            end
        end
        accept = '0;
        for (int i = 0; i < 3; i++)
            if (press[i] && !(m_phase == PH_IDLE && fv[i])) accept[i] = 1'b1;
`ifdef CALL_CANCEL_EN
        for (int i = 0; i < 3; i++)
            if (accept[i] && m_pend[i] &&
                !((m_phase == PH_REQUEST || m_phase == PH_TRAVEL) && m_target == i + 1))
                tog[i] = 1'b1;
`endif
        case (m_phase)
            PH_IDLE: if (m_pend != 0 && !moving) begin
                if (m_pend[m_cur-1]) clr[m_cur-1] = 1'b1;
                else begin
                    best = 0; bestd = 99;
                    for (int fl = 1; fl <= 3; fl++) if (m_pend[fl-1]) begin
                        d = (fl > m_cur) ? fl - m_cur : m_cur - fl;
                        if (d < bestd || (d == bestd && m_up)) begin best = fl; bestd = d; end
                    end
                    m_target = best; m_trip_up = (best > m_cur);
                    m_p = '0; m_p[best-1] = 1'b1; m_count = 0; m_phase = PH_REQUEST;
                end
            end
            PH_REQUEST: begin
                if (moving) begin m_p = '0; m_phase = PH_TRAVEL; end
                else begin
                    m_count++;
                    if (m_count == MTO) begin m_p = '0; m_phase = PH_IDLE; end
                end
            end
            PH_TRAVEL: if (fv[m_target-1] && !moving) begin
                clr[m_target-1] = 1'b1; m_up = m_trip_up; m_count = 0; m_phase = PH_DOORS;
            end
            default: begin
                m_count++;
                if (m_count == DWL) m_phase = PH_IDLE;
            end
        endcase
        m_pend = (m_pend | accept) & ~tog & ~clr;
        nf = 0;
        for (int i = 0; i < 3; i++) if (fv[i]) nf++;
        if (nf == 1) m_cur = fv[0] ? 1 : (fv[1] ? 2 : 3);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    function automatic logic [8:0] model_vec();
        logic [1:0] c;
        c = m_cur[1:0];
        return {m_p, m_pend, c, (m_phase != PH_IDLE)};
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            checks++;
            assert ({p3, p2, p1, pend, cur_floor, busy} === model_vec()) else begin
                failures++;
                $error("FAIL model_cycle t=%0t observed p/pend/cur/busy=%b required=%b",
                       $time, {p3, p2, p1, pend, cur_floor, busy}, model_vec());
            end
        end
    endtask

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h required=%0h", tag, obs, exp);
    endtask

    logic [9:0] p2_trace;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_eq("reset_p", {p3, p2, p1}, 0);
        expect_eq("reset_pend", pend, 0);
        expect_eq("reset_cur", cur_floor, 1);
        expect_eq("reset_busy", busy, 0);
        reset = 1'b1;
        f1 = 1'b1;
        tick(1);

        // Clean b3 press from floor 1, full trip to floor 3
        b3 = 1'b1;
        tick(5);
        expect_eq("b3_not_yet", pend, 3'b000);
        tick(1);
        expect_eq("b3_pend", pend, 3'b100);
        tick(1);
        expect_eq("b3_issue", {p3, p2, p1}, 3'b100);
        mup = 1'b1; f1 = 1'b0;
        tick(1);
        expect_eq("b3_p_drop", {p3, p2, p1}, 3'b000);
        tick(2);
        b3 = 1'b0;
        f3 = 1'b1; mup = 1'b0;
        tick(1);
        expect_eq("b3_arrive_pend", pend, 3'b000);
        tick(2);
        expect_eq("b3_dwell_busy", busy, 1);
        tick(1);
        expect_eq("b3_idle_busy", busy, 0);
        expect_eq("b3_cur", cur_floor, 3);

        // Bouncing b2 then held high: one press only
        for (int k = 0; k < 10; k++) begin
            b2 = ~b2;
            tick(2);
        end
        expect_eq("bounce_no_press", pend, 3'b000);
        b2 = 1'b1;
        tick(6);
        expect_eq("bounce_one_press", pend, 3'b010);

        // Request without motion: p2 high MTO cycles, one idle cycle, then retried
        for (int k = 0; k < 10; k++) begin
            tick(1);
            p2_trace[k] = p2;
        end
        expect_eq("timeout_pattern", p2_trace, 10'b10_1111_1111);
        expect_eq("timeout_pend", pend, 3'b010);
        mdw = 1'b1; f3 = 1'b0;
        tick(1);
        b2 = 1'b0;
        tick(2);
        f2 = 1'b1; mdw = 1'b0;
        tick(4);
        expect_eq("b2_arrive_cur", cur_floor, 2);

        // Tie at floor 2 after reset (direction up): floor 3 first, then floor 1
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        b1 = 1'b1; b3 = 1'b1;
        tick(6);
        expect_eq("tie_pend", pend, 3'b101);
        tick(1);
        expect_eq("tie_first_p3", {p3, p2, p1}, 3'b100);
        mup = 1'b1; f2 = 1'b0;
        tick(1);
        b1 = 1'b0; b3 = 1'b0;
        tick(2);
        f3 = 1'b1; mup = 1'b0;
        tick(1);
        expect_eq("tie_after_3", pend, 3'b001);
        tick(3);
        expect_eq("tie_p1_held", {p3, p2, p1}, 3'b000);
        tick(1);
        expect_eq("tie_then_p1", {p3, p2, p1}, 3'b001);
        mdw = 1'b1; f3 = 1'b0;
        tick(1);
        f2 = 1'b1;
        tick(1);
        f2 = 1'b0;
        tick(1);
        f1 = 1'b1; mdw = 1'b0;
        tick(4);

        // Re-press of a pending non-target floor while travelling to floor 3
        b3 = 1'b1;
        tick(6);
        b3 = 1'b0;
        tick(1);
        mup = 1'b1; f1 = 1'b0;
        tick(1);
        b2 = 1'b1;
        tick(6);
        expect_eq("cancel_first", pend, 3'b110);
        b2 = 1'b0;
        tick(6);
        b2 = 1'b1;
        tick(6);
`ifdef CALL_CANCEL_EN
        expect_eq("cancel_repress", pend, 3'b100);
`else
        expect_eq("cancel_repress", pend, 3'b110);
`endif
        expect_eq("moving_busy", busy, 1);

        // Asynchronous reset mid-move
        #2;
        reset = 1'b0;
        #1;
        expect_eq("async_p", {p3, p2, p1}, 0);
        expect_eq("async_pend", pend, 0);
        expect_eq("async_cur", cur_floor, 1);
        expect_eq("async_busy", busy, 0);
        b2 = 1'b0; mup = 1'b0; f1 = 1'b1;
        tick(2);
        reset = 1'b1;

        // Randomized phase against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) b1 = ~b1;
            if ($urandom_range(0, 11) == 0) b2 = ~b2;
            if ($urandom_range(0, 11) == 0) b3 = ~b3;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 9))
                    0:       {f3, f2, f1} = 3'b000;
                    1:       {f3, f2, f1} = 3'b011;
                    2, 3, 4: {f3, f2, f1} = 3'b001;
                    5, 6:    {f3, f2, f1} = 3'b010;
                    default: {f3, f2, f1} = 3'b100;
                endcase
            end
            if ($urandom_range(0, 4) == 0) mup = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) mdw = ($urandom_range(0, 3) == 0);
            tick(1);
            checks++;
            assert ((p1 + p2 + p3) <= 1) else begin
                failures++;
                $error("FAIL p_onehot t=%0t observed=%b required=at most one high", $time, {p3, p2, p1});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
